// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write-only controller: power-on init sequence, then
// byte-at-a-time command/data writes with E strobe timing and execution delays.
`timescale 1ns/1ps
module lcd_hd44780_ctrl #(
    parameter bit          BUS_4BIT    = 1'b0,
    parameter bit          TWO_LINE    = 1'b1,
    parameter int unsigned PWR_CYC     = 750000,
    parameter int unsigned WAKE_CYC    = 250000,
    parameter int unsigned E_CYC       = 50,
    parameter int unsigned NIB_GAP_CYC = 50,
    parameter int unsigned CMD_CYC     = 2000,
    parameter int unsigned CLR_CYC     = 90000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       init_done,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    // Handshake: a byte is taken on a clock edge where in_valid & in_ready;
    // in_ready is only high in READY and never while start is asserted.
    typedef enum logic [2:0] {
        S_IDLE, S_POWER, S_SETUP, S_PULSE, S_GAP, S_WAIT, S_READY
    } state_t;

    typedef struct packed {
        logic [7:0]  data;
        logic        single;
        logic [31:0] delay;
    } xfer_t;

    localparam logic [3:0] LAST_IDX = BUS_4BIT ? 4'd7 : 4'd3;
    localparam logic [7:0] FSET8    = {4'h3, TWO_LINE, 3'b000};
    localparam logic [7:0] FSET4    = {4'h2, TWO_LINE, 3'b000};

    function automatic logic [31:0] exec_delay(input logic rs, input logic [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03))
            return CLR_CYC;
        return CMD_CYC;
    endfunction

    // Single nibbles are stored in the high half so they go out on [7:4].
    function automatic xfer_t init_entry(input logic [3:0] i);
        xfer_t x;
        x.single = 1'b0;
        x.data   = 8'h06;
        if (BUS_4BIT) begin
            case (i)
                4'd0, 4'd1, 4'd2: begin x.data = 8'h30; x.single = 1'b1; end
                4'd3:             begin x.data = 8'h20; x.single = 1'b1; end
                4'd4:             x.data = FSET4;
                4'd5:             x.data = 8'h0C;
                4'd6:             x.data = 8'h01;
                default:          x.data = 8'h06;
            endcase
        end else begin
            case (i)
                4'd0:    x.data = FSET8;
                4'd1:    x.data = 8'h0C;
                4'd2:    x.data = 8'h01;
                default: x.data = 8'h06;
            endcase
        end
        x.delay = exec_delay(1'b0, x.data);
        if (x.single && i != 4'd3)
            x.delay = WAKE_CYC;
        return x;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        init_q, init_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        single_q, single_d;
    logic        lo_q, lo_d;
    logic [31:0] delay_q, delay_d;

    logic        ld;
    xfer_t       ld_x;
    logic        ld_rs;
    logic [31:0] lim;
    logic        at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            init_q   <= 1'b0;
            data_q   <= '0;
            rs_q     <= 1'b0;
            single_q <= 1'b0;
            lo_q     <= 1'b0;
            delay_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            init_q   <= init_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            single_q <= single_d;
            lo_q     <= lo_d;
            delay_q  <= delay_d;
        end
    end

    always_comb begin
        case (state_q)
            S_POWER: lim = PWR_CYC;
            S_PULSE: lim = E_CYC;
            S_GAP:   lim = NIB_GAP_CYC;
            S_WAIT:  lim = delay_q;
            default: lim = 32'd1;
        endcase
        at_end = (cnt_q == lim - 32'd1);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        idx_d    = idx_q;
        init_d   = init_q;
        data_d   = data_q;
        rs_d     = rs_q;
        single_d = single_q;
        lo_d     = lo_q;
        delay_d  = delay_q;
        ld       = 1'b0;
        ld_x     = '0;
        ld_rs    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_POWER;
                    idx_d   = '0;
                    init_d  = 1'b1;
                end
            end
            S_POWER: begin
                if (at_end) begin
                    ld   = 1'b1;
                    ld_x = init_entry(4'd0);
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                cnt_d   = '0;
            end
            S_PULSE: begin
                if (at_end) begin
                    cnt_d   = '0;
                    state_d = (BUS_4BIT && !single_q && !lo_q) ? S_GAP : S_WAIT;
                end
            end
            S_GAP: begin
                if (at_end) begin
                    cnt_d   = '0;
                    state_d = S_SETUP;
                    lo_d    = 1'b1;
                end
            end
            S_WAIT: begin
                if (at_end) begin
                    if (init_q && idx_q != LAST_IDX) begin
                        idx_d = idx_q + 4'd1;
                        ld    = 1'b1;
                        ld_x  = init_entry(idx_q + 4'd1);
                    end else begin
                        state_d = S_READY;
                        init_d  = 1'b0;
                        cnt_d   = '0;
                        data_d  = '0;
                        rs_d    = 1'b0;
                        lo_d    = 1'b0;
                    end
                end
            end
            S_READY: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_POWER;
                    idx_d   = '0;
                    init_d  = 1'b1;
                end else if (in_valid) begin
                    ld          = 1'b1;
                    ld_x.data   = in_data;
                    ld_x.single = 1'b0;
                    ld_x.delay  = exec_delay(in_rs, in_data);
                    ld_rs       = in_rs;
                    init_d      = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (ld) begin
            state_d  = S_SETUP;
            cnt_d    = '0;
            data_d   = ld_x.data;
            single_d = ld_x.single;
            delay_d  = ld_x.delay;
            rs_d     = ld_rs;
            lo_d     = 1'b0;
        end
    end

    always_comb begin
        lcd_rw    = 1'b0;
        lcd_e     = (state_q == S_PULSE);
        init_done = (state_q == S_READY);
        in_ready  = (state_q == S_READY) && !start;
        lcd_data  = '0;
        lcd_rs    = 1'b0;
        if (state_q == S_SETUP || state_q == S_PULSE || state_q == S_GAP || state_q == S_WAIT) begin
            lcd_rs   = rs_q;
            lcd_data = BUS_4BIT ? {(lo_q ? data_q[3:0] : data_q[7:4]), 4'h0} : data_q;
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl: one 8-bit and one 4-bit instance with
// short timing parameters, hand-computed pulse sequences and latencies.
`timescale 1ns/1ps
module tb_lcd_hd44780_ctrl;

    logic clk, rst;
    logic start8, valid8, rs8_in;
    logic [7:0] data8_in;
    logic done8, ready8, lcd_rs8, lcd_rw8, lcd_e8;
    logic [7:0] lcd_data8;
    logic start4, valid4, rs4_in;
    logic [7:0] data4_in;
    logic done4, ready4, lcd_rs4, lcd_rw4, lcd_e4;
    logic [7:0] lcd_data4;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] pq_data[$];
    logic       pq_rs[$];
    int         pq_len[$];
    int         pq_gap[$];
    int         stab_err, ready_err, rw_err;

    logic [7:0] exp8 [4]  = '{8'h38, 8'h0C, 8'h01, 8'h06};
    int         gap8 [3]  = '{6, 6, 13};
    logic [7:0] exp4 [12] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80,
                              8'h00, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h60};
    int         gap4 [11] = '{9, 9, 9, 6, 3, 6, 3, 6, 3, 13, 3};

    lcd_hd44780_ctrl #(
        .BUS_4BIT(1'b0), .TWO_LINE(1'b1), .PWR_CYC(20), .WAKE_CYC(8),
        .E_CYC(3), .NIB_GAP_CYC(2), .CMD_CYC(5), .CLR_CYC(12)
    ) u8 (
        .clk(clk), .rst(rst), .start(start8), .init_done(done8),
        .in_valid(valid8), .in_ready(ready8), .in_rs(rs8_in), .in_data(data8_in),
        .lcd_data(lcd_data8), .lcd_rs(lcd_rs8), .lcd_rw(lcd_rw8), .lcd_e(lcd_e8)
    );

    lcd_hd44780_ctrl #(
        .BUS_4BIT(1'b1), .TWO_LINE(1'b1), .PWR_CYC(20), .WAKE_CYC(8),
        .E_CYC(3), .NIB_GAP_CYC(2), .CMD_CYC(5), .CLR_CYC(12)
    ) u4 (
        .clk(clk), .rst(rst), .start(start4), .init_done(done4),
        .in_valid(valid4), .in_ready(ready4), .in_rs(rs4_in), .in_data(data4_in),
        .lcd_data(lcd_data4), .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_e(lcd_e4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Records E pulses of one instance until init_done or the cycle budget.
    task automatic watch(input bit sel, input int n0, input int max_cyc,
                         output int n_done, output bit tmo);
        int n, len, low;
        logic e, prev_e, rs, dn, rdy, rw;
        logic [7:0] d, prev_d;
        bit seen;
        pq_data.delete(); pq_rs.delete(); pq_len.delete(); pq_gap.delete();
        stab_err = 0; ready_err = 0; rw_err = 0;
        n = n0; len = 0; low = 0; seen = 0; tmo = 1; n_done = -1;
        prev_e = sel ? lcd_e4 : lcd_e8;
        prev_d = sel ? lcd_data4 : lcd_data8;
        while (n < max_cyc) begin
            @(posedge clk); #1; n++;
            e   = sel ? lcd_e4 : lcd_e8;
            d   = sel ? lcd_data4 : lcd_data8;
            rs  = sel ? lcd_rs4 : lcd_rs8;
            dn  = sel ? done4 : done8;
            rdy = sel ? ready4 : ready8;
            rw  = sel ? lcd_rw4 : lcd_rw8;
            if (rw !== 1'b0) rw_err++;
            if (!dn && rdy) ready_err++;
            if (e && !prev_e) begin
                if (d !== prev_d) stab_err++;
                pq_data.push_back(d);
                pq_rs.push_back(rs);
                if (seen) pq_gap.push_back(low);
                len = 1; seen = 1;
            end else if (e) begin
                len++;
                if (d !== prev_d) stab_err++;
            end else if (prev_e) begin
                if (d !== prev_d) stab_err++;
                pq_len.push_back(len);
                low = 1;
            end else begin
                low++;
            end
            if (dn) begin
                n_done = n; tmo = 0;
                break;
            end
            prev_e = e; prev_d = d;
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        tests_run++;
        if ({lcd_e8, lcd_data8, lcd_rs8, lcd_rw8, done8, ready8} !== 12'h0) begin
            $display("FAIL reset_out8: got e=%b d=%h rs=%b rw=%b done=%b rdy=%b, want all 0",
                     lcd_e8, lcd_data8, lcd_rs8, lcd_rw8, done8, ready8);
            tests_failed++;
        end
        tests_run++;
        if ({lcd_e4, lcd_data4, lcd_rs4, lcd_rw4, done4, ready4} !== 12'h0) begin
            $display("FAIL reset_out4: got e=%b d=%h rs=%b rw=%b done=%b rdy=%b, want all 0",
                     lcd_e4, lcd_data4, lcd_rs4, lcd_rw4, done4, ready4);
            tests_failed++;
        end
        @(negedge clk); rst = 1'b0;
        valid8 = 1'b1; rs8_in = 1'b1; data8_in = 8'h55;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (lcd_e8 !== 1'b0 || done8 !== 1'b0 || ready8 !== 1'b0 || lcd_data8 !== 8'h00) begin
                $display("FAIL idle_quiet cycle %0d: e=%b done=%b rdy=%b d=%h, want 0/0/0/00",
                         i, lcd_e8, done8, ready8, lcd_data8);
                tests_failed++;
            end
        end
        valid8 = 1'b0;
    endtask

    task automatic test_init_8bit();
        int n; bit tmo;
        @(negedge clk) start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        watch(1'b0, 1, 400, n, tmo);
        tests_run++;
        if (tmo || n != 64) begin
            $display("FAIL init8_latency: got %0d (timeout=%0d), want 64", n, tmo);
            tests_failed++;
        end
        tests_run++;
        if (pq_data.size() != 4 || pq_len.size() != 4 || pq_gap.size() != 3) begin
            $display("FAIL init8_count: got %0d pulses/%0d gaps, want 4/3", pq_data.size(), pq_gap.size());
            tests_failed++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (pq_data[i] !== exp8[i] || pq_len[i] != 3 || pq_rs[i] !== 1'b0) begin
                    $display("FAIL init8_pulse%0d: got d=%h len=%0d rs=%b, want d=%h len=3 rs=0",
                             i, pq_data[i], pq_len[i], pq_rs[i], exp8[i]);
                    tests_failed++;
                end
            end
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (pq_gap[i] != gap8[i]) begin
                    $display("FAIL init8_gap%0d: got %0d, want %0d", i, pq_gap[i], gap8[i]);
                    tests_failed++;
                end
            end
        end
        tests_run++;
        if (stab_err != 0 || ready_err != 0 || rw_err != 0) begin
            $display("FAIL init8_stable: got stab=%0d rdy=%0d rw=%0d, want 0/0/0", stab_err, ready_err, rw_err);
            tests_failed++;
        end
        tests_run++;
        if (lcd_data8 !== 8'h00 || lcd_rs8 !== 1'b0 || lcd_e8 !== 1'b0 || ready8 !== 1'b1) begin
            $display("FAIL init8_ready_out: got d=%h rs=%b e=%b rdy=%b, want 00/0/0/1",
                     lcd_data8, lcd_rs8, lcd_e8, ready8);
            tests_failed++;
        end
    endtask

    task automatic test_user_write();
        logic       v_rs [2] = '{1'b1, 1'b0};
        logic [7:0] v_d  [2] = '{8'h41, 8'h01};
        int         v_n  [2] = '{9, 16};
        int n; bit tmo;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            valid8 = 1'b1; rs8_in = v_rs[k]; data8_in = v_d[k];
            #1;
            tests_run++;
            if (ready8 !== 1'b1) begin
                $display("FAIL write%0d_ready: got %b, want 1", k, ready8);
                tests_failed++;
            end
            @(posedge clk); #1 valid8 = 1'b0;
            watch(1'b0, 0, 100, n, tmo);
            tests_run++;
            if (tmo || n != v_n[k]) begin
                $display("FAIL write%0d_latency: got %0d (timeout=%0d), want %0d", k, n, tmo, v_n[k]);
                tests_failed++;
            end
            tests_run++;
            if (pq_data.size() != 1 || pq_len.size() != 1) begin
                $display("FAIL write%0d_count: got %0d pulses, want 1", k, pq_data.size());
                tests_failed++;
            end else if (pq_data[0] !== v_d[k] || pq_rs[0] !== v_rs[k] || pq_len[0] != 3) begin
                $display("FAIL write%0d_pulse: got d=%h rs=%b len=%0d, want d=%h rs=%b len=3",
                         k, pq_data[0], pq_rs[0], pq_len[0], v_d[k], v_rs[k]);
                tests_failed++;
            end
            tests_run++;
            if (stab_err != 0 || ready_err != 0) begin
                $display("FAIL write%0d_busy: got stab=%0d rdy_while_busy=%0d, want 0/0", k, stab_err, ready_err);
                tests_failed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b_d  [3] = '{8'h48, 8'h49, 8'h02};
        logic       b_rs [3] = '{1'b1, 1'b1, 1'b0};
        int acc_cyc[$];
        logic [7:0] acc_d[$];
        logic [7:0] pul[$];
        int k, cyc;
        bit will, prev_e;
        k = 0; cyc = 0; prev_e = 1'b0;
        @(negedge clk);
        valid8 = 1'b1; data8_in = b_d[0]; rs8_in = b_rs[0];
        while (cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            will = valid8 && ready8;
            @(posedge clk); #1; cyc++;
            if (will) begin
                acc_cyc.push_back(cyc);
                acc_d.push_back(data8_in);
                k++;
                if (k < 3) begin
                    data8_in = b_d[k]; rs8_in = b_rs[k];
                end else begin
                    valid8 = 1'b0;
                end
            end
            if (lcd_e8 && !prev_e) pul.push_back(lcd_data8);
            prev_e = lcd_e8;
            if (k == 3 && done8) break;
        end
        valid8 = 1'b0;
        tests_run++;
        if (acc_cyc.size() != 3 || cyc >= 200) begin
            $display("FAIL b2b_accepts: got %0d accepts in %0d cycles, want 3", acc_cyc.size(), cyc);
            tests_failed++;
        end else begin
            tests_run++;
            if (acc_cyc[0] != 1 || acc_cyc[1] - acc_cyc[0] != 10 || acc_cyc[2] - acc_cyc[1] != 10) begin
                $display("FAIL b2b_spacing: got accepts at %0d,%0d,%0d, want 1,11,21",
                         acc_cyc[0], acc_cyc[1], acc_cyc[2]);
                tests_failed++;
            end
            tests_run++;
            if (cyc - acc_cyc[2] != 16) begin
                $display("FAIL b2b_last_latency: got %0d, want 16", cyc - acc_cyc[2]);
                tests_failed++;
            end
        end
        tests_run++;
        if (pul.size() != 3) begin
            $display("FAIL b2b_pulses: got %0d pulses, want 3", pul.size());
            tests_failed++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (pul[i] !== b_d[i]) begin
                    $display("FAIL b2b_byte%0d: got %h, want %h", i, pul[i], b_d[i]);
                    tests_failed++;
                end
            end
        end
    endtask

    task automatic test_start_priority();
        int n; bit tmo;
        @(negedge clk);
        valid8 = 1'b1; rs8_in = 1'b1; data8_in = 8'h41; start8 = 1'b1;
        #1;
        tests_run++;
        if (ready8 !== 1'b0 || done8 !== 1'b1) begin
            $display("FAIL prio_ready: got rdy=%b done=%b, want 0/1", ready8, done8);
            tests_failed++;
        end
        @(posedge clk); #1;
        start8 = 1'b0; valid8 = 1'b0;
        tests_run++;
        if (done8 !== 1'b0 || lcd_e8 !== 1'b0 || lcd_data8 !== 8'h00) begin
            $display("FAIL prio_power: got done=%b e=%b d=%h, want 0/0/00", done8, lcd_e8, lcd_data8);
            tests_failed++;
        end
        watch(1'b0, 1, 400, n, tmo);
        tests_run++;
        if (tmo || n != 64) begin
            $display("FAIL prio_reinit_latency: got %0d (timeout=%0d), want 64", n, tmo);
            tests_failed++;
        end
        tests_run++;
        if (pq_data.size() != 4) begin
            $display("FAIL prio_reinit_count: got %0d pulses, want 4", pq_data.size());
            tests_failed++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (pq_data[i] !== exp8[i]) begin
                    $display("FAIL prio_reinit%0d: got %h, want %h", i, pq_data[i], exp8[i]);
                    tests_failed++;
                end
            end
        end
    endtask

    task automatic test_init_4bit();
        int n; bit tmo;
        @(negedge clk) start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        watch(1'b1, 1, 600, n, tmo);
        tests_run++;
        if (tmo || n != 133) begin
            $display("FAIL init4_latency: got %0d (timeout=%0d), want 133", n, tmo);
            tests_failed++;
        end
        tests_run++;
        if (pq_data.size() != 12 || pq_len.size() != 12 || pq_gap.size() != 11) begin
            $display("FAIL init4_count: got %0d pulses/%0d gaps, want 12/11", pq_data.size(), pq_gap.size());
            tests_failed++;
        end else begin
            for (int i = 0; i < 12; i++) begin
                tests_run++;
                if (pq_data[i] !== exp4[i] || pq_len[i] != 3 || pq_rs[i] !== 1'b0) begin
                    $display("FAIL init4_pulse%0d: got d=%h len=%0d rs=%b, want d=%h len=3 rs=0",
                             i, pq_data[i], pq_len[i], pq_rs[i], exp4[i]);
                    tests_failed++;
                end
            end
            for (int i = 0; i < 11; i++) begin
                tests_run++;
                if (pq_gap[i] != gap4[i]) begin
                    $display("FAIL init4_gap%0d: got %0d, want %0d", i, pq_gap[i], gap4[i]);
                    tests_failed++;
                end
            end
        end
        tests_run++;
        if (stab_err != 0 || ready_err != 0 || rw_err != 0) begin
            $display("FAIL init4_stable: got stab=%0d rdy=%0d rw=%0d, want 0/0/0", stab_err, ready_err, rw_err);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid_pulse();
        int i; bit found;
        found = 0;
        @(negedge clk) start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        for (i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (lcd_e4) begin
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            $display("FAIL rstmid_pulse_seen: got no E pulse in 100 cycles, want one");
            tests_failed++;
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (lcd_e4 !== 1'b0 || lcd_data4 !== 8'h00 || done4 !== 1'b0 || lcd_rs4 !== 1'b0) begin
            $display("FAIL rstmid_async: got e=%b d=%h done=%b rs=%b, want 0/00/0/0",
                     lcd_e4, lcd_data4, done4, lcd_rs4);
            tests_failed++;
        end
        tests_run++;
        if (done8 !== 1'b0 || ready8 !== 1'b0) begin
            $display("FAIL rstmid_async8: got done=%b rdy=%b, want 0/0", done8, ready8);
            tests_failed++;
        end
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (lcd_e4 !== 1'b0 || done4 !== 1'b0 || lcd_data4 !== 8'h00 || lcd_e8 !== 1'b0 || done8 !== 1'b0) begin
                $display("FAIL rstmid_quiet cycle %0d: got e4=%b done4=%b d4=%h e8=%b done8=%b, want all 0",
                         c, lcd_e4, done4, lcd_data4, lcd_e8, done8);
                tests_failed++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; valid8 = 1'b0; rs8_in = 1'b0; data8_in = 8'h00;
        start4 = 1'b0; valid4 = 1'b0; rs4_in = 1'b0; data4_in = 8'h00;
        repeat (3) @(posedge clk);
        test_reset();
        test_init_8bit();
        test_user_write();
        test_back_to_back();
        test_start_priority();
        test_init_4bit();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
